frame_serializer: RTL and testbench

- Downstream of the octo sensor manager and upstream of the byte-level UART shifter.
- Runs in the 12 MHz UART domain.
- Takes the 272-bit sensor_iterations word when the producer flags data available, acknowledges it with a reset_parser pulse, and emits a framed byte stream over a valid/ready byte interface.
- Frame format: two sync bytes, 34 payload bytes MSB-first, one checksum byte.

---
 rtl/frame_serializer_if.sv | 19 +
 rtl/frame_serializer.sv | 190 +++++++++++++++++++
 tb/tb_frame_serializer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_serializer_if.sv
// Byte stream link from the frame serializer to the UART shifter.
// A byte moves on a clock edge where byte_valid and byte_ready are both high.
interface frame_serializer_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/frame_serializer.sv
// Frames the sensor_iterations word as SYNC0 SYNC1, the payload MSB-first, then a checksum byte.
// Define FRAME_SERIALIZER_CRC8_EN to send CRC-8 (poly 0x07) in place of the additive checksum.
module frame_serializer #(
  parameter int         PAYLOAD_BYTES = 34,
  parameter logic [7:0] SYNC0         = 8'hA5,
  parameter logic [7:0] SYNC1         = 8'h5A,
  parameter int         GAP_CYCLES    = 16
) (
  input  logic                       clk_12MHz,
  input  logic                       reset,
  input  logic                       data_availible,
  input  logic [8*PAYLOAD_BYTES-1:0] sensor_iterations,
  output logic                       reset_parser,
  output logic                       busy,
  frame_serializer_if.master         byte_if
);

  localparam int FRAME_W = 8 * PAYLOAD_BYTES;
  localparam int IDX_W   = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    SYNC_A  = 3'd2,
    SYNC_B  = 3'd3,
    PAYLOAD = 3'd4,
    CHECK   = 3'd5,
    GAP     = 3'd6
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         sync_reg;
  logic               sync_avl;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic [7:0]         checksum_reg, checksum_next;
  logic [IDX_W-1:0]   index_reg, index_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               seen_low_reg, seen_low_next;

  logic [7:0]         tx_byte;
  logic               tx_valid;
  logic               xfer;
  logic [7:0]         payload_byte;
  logic [7:0]         checksum_upd;

  assign sync_avl     = sync_reg[1];
  assign xfer         = tx_valid & byte_if.byte_ready;
  // The frame register shifts left per payload byte, so the current byte is always on top.
  assign payload_byte = frame_reg[FRAME_W-1 -: 8];

`ifdef FRAME_SERIALIZER_CRC8_EN
  logic [7:0] crc_stage [0:8];

  assign crc_stage[0] = checksum_reg ^ payload_byte;
  for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
    assign crc_stage[gi+1] = crc_stage[gi][7] ? ({crc_stage[gi][6:0], 1'b0} ^ 8'h07)
                                              :  {crc_stage[gi][6:0], 1'b0};
  end
  assign checksum_upd = crc_stage[8];
`else
  assign checksum_upd = checksum_reg + payload_byte;
`endif

  // State and datapath registers
  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      sync_reg     <= 2'b00;
      frame_reg    <= '0;
      checksum_reg <= 8'h00;
      index_reg    <= '0;
      gap_cnt_reg  <= '0;
      seen_low_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sync_reg     <= {sync_reg[0], data_availible};
      frame_reg    <= frame_next;
      checksum_reg <= checksum_next;
      index_reg    <= index_next;
      gap_cnt_reg  <= gap_cnt_next;
      seen_low_reg <= seen_low_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next    = state_reg;
    frame_next    = frame_reg;
    checksum_next = checksum_reg;
    index_next    = index_reg;
    gap_cnt_next  = gap_cnt_reg;
    // A low level seen after the acknowledge means a later high is a fresh request.
    seen_low_next = seen_low_reg | ~sync_avl;

    case (state_reg)
      IDLE: begin
        if (sync_avl) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        frame_next    = sensor_iterations;
        checksum_next = 8'h00;
        index_next    = '0;
        seen_low_next = 1'b0;
        state_next    = SYNC_A;
      end
      SYNC_A: begin
        if (xfer) begin
          state_next = SYNC_B;
        end
      end
      SYNC_B: begin
        if (xfer) begin
          index_next = '0;
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          checksum_next = checksum_upd;
          frame_next    = {frame_reg[FRAME_W-9:0], 8'h00};
          if (index_reg == IDX_LAST) begin
            index_next = '0;
            state_next = CHECK;
          end else begin
            index_next = index_reg + 1'b1;
          end
        end
      end
      CHECK: begin
        if (xfer) begin
          gap_cnt_next = '0;
          state_next   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_reg != GAP_LAST) begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end else if (!sync_avl || seen_low_reg) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decode from the state register only, so reset clears them at once.
  always_comb begin
    tx_byte      = 8'h00;
    tx_valid     = 1'b0;
    reset_parser = 1'b0;
    busy         = (state_reg != IDLE);

    case (state_reg)
      LATCH: begin
        reset_parser = 1'b1;
      end
      SYNC_A: begin
        tx_byte  = SYNC0;
        tx_valid = 1'b1;
      end
      SYNC_B: begin
        tx_byte  = SYNC1;
        tx_valid = 1'b1;
      end
      PAYLOAD: begin
        tx_byte  = payload_byte;
        tx_valid = 1'b1;
      end
      CHECK: begin
        tx_byte  = checksum_reg;
        tx_valid = 1'b1;
      end
      default: begin
        tx_byte  = 8'h00;
        tx_valid = 1'b0;
      end
    endcase
  end

  assign byte_if.byte_data  = tx_byte;
  assign byte_if.byte_valid = tx_valid;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: frame content, stalls, hand-off, gap and reset abort.
// With FRAME_SERIALIZER_CRC8_EN defined the checksum expectations follow CRC-8.
module tb_frame_serializer;

  logic         clk_12MHz = 1'b0;
  logic         reset;
  logic         data_availible;
  logic [271:0] sensor_iterations;
  logic         reset_parser;
  logic         busy;

  frame_serializer_if bif ();

  frame_serializer dut (
    .clk_12MHz         (clk_12MHz),
    .reset             (reset),
    .data_availible    (data_availible),
    .sensor_iterations (sensor_iterations),
    .reset_parser      (reset_parser),
    .busy              (busy),
    .byte_if           (bif)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         ack_count = 0;
  logic [7:0] rx_q [$];
  int         xfer_cyc [$];
  int         ack_cyc [$];
  bit         hold_pending = 1'b0;
  logic [7:0] hold_data = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

`ifdef FRAME_SERIALIZER_CRC8_EN
  function automatic logic [7:0] crc8_model(input logic [271:0] pl);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 34; i++) begin
      c = c ^ pl[271-8*i -: 8];
      for (int b = 0; b < 8; b++) begin
        c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction
`endif

  // Observe the link between edges: record transfers, acknowledges and stall stability.
  always @(negedge clk_12MHz) begin
    cyc++;
    if (hold_pending && !reset) begin
      check_eq("stall_valid", 32'(bif.byte_valid), 32'd1);
      check_eq("stall_hold", 32'(bif.byte_data), 32'(hold_data));
    end
    hold_pending = !reset && bif.byte_valid && !bif.byte_ready;
    hold_data    = bif.byte_data;
    if (!reset && bif.byte_valid && bif.byte_ready) begin
      rx_q.push_back(bif.byte_data);
      xfer_cyc.push_back(cyc);
    end
    if (reset_parser) begin
      ack_count++;
      ack_cyc.push_back(cyc);
    end
  end

  task automatic run_frame(input logic [271:0] pl, input logic [7:0] exp_ck,
                           input string tag, input bit toggle, output int lat);
    int         a0;
    logic [7:0] exp_b;
    @(posedge clk_12MHz); #1;
    rx_q.delete();
    xfer_cyc.delete();
    a0                = ack_count;
    lat               = 0;
    sensor_iterations = pl;
    data_availible    = 1'b1;
    bif.byte_ready    = 1'b1;
    for (int c = 0; c < 600 && rx_q.size() < 37; c++) begin
      @(posedge clk_12MHz); #1;
      if (busy && lat == 0) lat = c + 1;
      if (toggle) bif.byte_ready = ~bif.byte_ready;
    end
    check_eq({tag, "_nbytes"}, 32'(rx_q.size()), 32'd37);
    for (int i = 0; i < 37 && i < rx_q.size(); i++) begin
      if (i == 0)       exp_b = 8'hA5;
      else if (i == 1)  exp_b = 8'h5A;
      else if (i == 36) exp_b = exp_ck;
      else              exp_b = pl[271-8*(i-2) -: 8];
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_b));
    end
    check_eq({tag, "_acks"}, 32'(ack_count - a0), 32'd1);
    if (!toggle) begin
      check_eq({tag, "_consecutive"},
               (xfer_cyc.size() >= 37) ? 32'(xfer_cyc[36] - xfer_cyc[0]) : 32'hFFFF_FFFF, 32'd36);
    end
    data_availible = 1'b0;
    bif.byte_ready = 1'b1;
    for (int c = 0; c < 100 && busy; c++) begin
      @(posedge clk_12MHz); #1;
    end
    check_eq({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [271:0] pl_a, pl_ff, pl_c;
    logic [7:0]   ck_a, ck_ff, ck_c;
    int           lat, a0;

    for (int i = 0; i < 34; i++) begin
      pl_a[271-8*i -: 8] = 8'(i + 1);
      pl_c[271-8*i -: 8] = 8'(7 * i + 3);
    end
    pl_ff = '1;
`ifdef FRAME_SERIALIZER_CRC8_EN
    ck_a  = crc8_model(pl_a);
    ck_ff = crc8_model(pl_ff);
    ck_c  = crc8_model(pl_c);
`else
    ck_a  = 8'h53;
    ck_ff = 8'hDE;
    ck_c  = 8'hBD;
`endif

    reset             = 1'b1;
    data_availible    = 1'b0;
    sensor_iterations = '0;
    bif.byte_ready    = 1'b0;
    repeat (3) @(posedge clk_12MHz);
    #1;
    check_eq("rst_byte_valid", 32'(bif.byte_valid), 32'd0);
    check_eq("rst_byte_data", 32'(bif.byte_data), 32'd0);
    check_eq("rst_reset_parser", 32'(reset_parser), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    #1 reset = 1'b0;

    repeat (100) begin
      @(posedge clk_12MHz); #1;
      check_eq("idle_outputs", {29'd0, bif.byte_valid, reset_parser, busy}, 32'd0);
    end

    run_frame(pl_a, ck_a, "frameA", 1'b0, lat);
    check_eq("avl_latency_2to3", 32'(lat >= 2 && lat <= 3), 32'd1);

    run_frame(pl_ff, ck_ff, "frameFF_stall", 1'b1, lat);

    // Level held long after the acknowledge, then a fresh request mid-frame.
    @(posedge clk_12MHz); #1;
    rx_q.delete(); xfer_cyc.delete(); ack_cyc.delete();
    a0                = ack_count;
    sensor_iterations = pl_c;
    data_availible    = 1'b1;
    bif.byte_ready    = 1'b1;
    repeat (500) @(posedge clk_12MHz);
    #1;
    check_eq("held_acks", 32'(ack_count - a0), 32'd1);
    check_eq("held_nbytes", 32'(rx_q.size()), 32'd37);
    data_availible = 1'b0;
    repeat (10) @(posedge clk_12MHz);
    #1;
    check_eq("held_low_acks", 32'(ack_count - a0), 32'd1);
    check_eq("held_low_idle", 32'(busy), 32'd0);
    data_availible = 1'b1;
    for (int c = 0; c < 200 && ack_count < a0 + 2; c++) begin
      @(posedge clk_12MHz); #1;
    end
    data_availible = 1'b0;
    repeat (3) @(posedge clk_12MHz);
    #1;
    data_availible = 1'b1;
    for (int c = 0; c < 400 && ack_count < a0 + 3; c++) begin
      @(posedge clk_12MHz); #1;
    end
    check_eq("b2b_acks", 32'(ack_count - a0), 32'd3);
    check_eq("b2b_nbytes", 32'(rx_q.size() >= 74 && ack_cyc.size() >= 3), 32'd1);
    if (rx_q.size() >= 74 && ack_cyc.size() >= 3) begin
      check_eq("b2b_gap_ge16", 32'((ack_cyc[2] - xfer_cyc[73]) >= 17), 32'd1);
      check_eq("b2b_f2_sync", 32'(rx_q[37]), 32'hA5);
      check_eq("b2b_f2_ck", 32'(rx_q[73]), 32'(ck_c));
    end
    data_availible = 1'b0;
    for (int c = 0; c < 300 && (busy || rx_q.size() < 111); c++) begin
      @(posedge clk_12MHz); #1;
    end
    check_eq("b2b_f3_nbytes", 32'(rx_q.size()), 32'd111);
    check_eq("b2b_idle", 32'(busy), 32'd0);

    // Abort a frame at payload index 10.
    @(posedge clk_12MHz); #1;
    rx_q.delete(); xfer_cyc.delete();
    a0                = ack_count;
    sensor_iterations = pl_c;
    data_availible    = 1'b1;
    bif.byte_ready    = 1'b1;
    for (int c = 0; c < 200 && rx_q.size() < 12; c++) begin
      @(posedge clk_12MHz); #2;
    end
    check_eq("abort_at_idx10", 32'(rx_q.size()), 32'd12);
    reset = 1'b1;
    #1;
    check_eq("abort_valid", 32'(bif.byte_valid), 32'd0);
    check_eq("abort_data", 32'(bif.byte_data), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    data_availible = 1'b0;
    repeat (2) @(posedge clk_12MHz);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_no_extra_ack", 32'(ack_count - a0), 32'd1);
    check_eq("abort_parser_low", 32'(reset_parser), 32'd0);
    run_frame(pl_c, ck_c, "fresh", 1'b0, lat);

`ifdef FRAME_SERIALIZER_CRC8_EN
    begin
      logic [271:0] pl_one;
      pl_one = '0;
      pl_one[271:264] = 8'h01;
      run_frame(pl_one, crc8_model(pl_one), "crc_one", 1'b0, lat);
      run_frame('0, 8'h00, "crc_zero", 1'b0, lat);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
